// File: rtl/decoder_scan_if.sv
// Control and result bundle for decoder_scan: mode/select inputs, one-hot
// output with its binary index and status strobes.
interface decoder_scan_if #(
   parameter int unsigned N       = 2,
   parameter int unsigned DWELL_W = 8
);
   localparam int unsigned OUTS = 2 ** N;

   logic               en;
   logic [1:0]         mode;
   logic [N-1:0]       sel;
   logic [DWELL_W-1:0] dwell;
   logic [OUTS-1:0]    y;
   logic [N-1:0]       idx;
   logic               valid;
   logic               wrap;

   modport master (output en, mode, sel, dwell, input  y, idx, valid, wrap);
   modport slave  (input  en, mode, sel, dwell, output y, idx, valid, wrap);
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2**N one-hot decoder with auto-scan (dwell-timed walk of the
// active output) and hold modes.
module decoder_scan #(
   parameter int unsigned N       = 2,
   parameter int unsigned DWELL_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   decoder_scan_if.slave bus
);
   localparam int unsigned OUTS = 2 ** N;

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SCAN, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [OUTS-1:0]    y_q, y_d;
   logic [N-1:0]       idx_q, idx_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         y_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;

      if (!bus.en) begin
         state_d = S_IDLE;
      end else begin
         case (bus.mode)
            2'd0:    state_d = S_DECODE;
            2'd1:    state_d = S_SCAN;
            default: state_d = S_HOLD;
         endcase
      end

      // Actions are keyed on the state being entered; SCAN also looks at where
      // it came from, since HOLD resumes the walk while IDLE/DECODE restart it.
      case (state_d)
         S_IDLE: begin
            y_d     = '0;
            valid_d = 1'b0;
         end
         S_DECODE: begin
            y_d     = OUTS'(1) << bus.sel;
            idx_d   = bus.sel;
            valid_d = 1'b1;
         end
         S_SCAN: begin
            if (state_q == S_IDLE || state_q == S_DECODE) begin
               y_d     = OUTS'(1) << bus.sel;
               idx_d   = bus.sel;
               cnt_d   = bus.dwell;
               valid_d = 1'b1;
            end else if (cnt_q == '0) begin
               idx_d  = idx_q + 1'b1;
               y_d    = {y_q[OUTS-2:0], y_q[OUTS-1]};
               cnt_d  = bus.dwell;
               wrap_d = (idx_q == '1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.y     = y_q;
   assign bus.idx   = idx_q;
   assign bus.valid = valid_q;
   assign bus.wrap  = wrap_q;
endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
Parametrised, registered binary-to-one-hot decoder. It generalises the 2-to-4 enabled decoder to N select bits and 2**N outputs. It adds an auto-scan mode, in which a dwell counter walks the active output through all positions, and a hold mode that freezes the output. Typical uses are multiplexed display digit-select, round-robin channel strobes and test-pattern sweeps.

Parameters:
N, 2, select width; the output vector has OUTS = 2**N bits (derived localparam).
DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; en=0 overrides mode
mode  input  2  0=DECODE, 1=SCAN, 2=HOLD, 3=reserved (behaves as HOLD)
sel  input  N  decode index in DECODE; start index on entry to SCAN
dwell  input  DWELL_W  extra cycles per scan position (0 = advance every cycle)
y  output  OUTS  registered one-hot output, or all-zero
idx  output  N  binary index of the active y bit
valid  output  1  high when y is one-hot
wrap  output  1  one-cycle pulse when scan wraps from OUTS-1 to 0

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately):
  - y=0, idx=0, valid=0, wrap=0.
  - dwell counter cnt=0, state=IDLE.
  - Reset asserted mid-scan clears everything with no completion of the dwell.
- States: IDLE, DECODE, SCAN, HOLD. The next state is evaluated on every rising clk edge.
- Priority: en=0 forces IDLE over any mode. Otherwise mode selects the state, with mode 3 mapping to HOLD.
- IDLE (en=0):
  - y<=0, valid<=0, wrap<=0.
  - idx and cnt are retained.
- DECODE, 1-cycle latency:
  - Each edge: y<=1<<sel, idx<=sel, valid<=1, wrap<=0.
  - sel changes are reflected on the next edge.
- SCAN entry, from IDLE or DECODE (or from reset state):
  - idx<=sel, y<=1<<sel, cnt<=dwell, valid<=1, wrap<=0.
- SCAN steady state, each edge:
  - If cnt==0: idx<=idx+1 mod OUTS, y<=rotate-left(y,1), cnt<=dwell (re-sampled at this reload), wrap<=(idx==OUTS-1).
  - Otherwise: cnt<=cnt-1, wrap<=0.
  - Each position is shown for dwell+1 cycles.
  - idx arithmetic wraps naturally in N bits; no overflow state exists.
- HOLD:
  - y, idx, cnt and valid are frozen; wrap<=0.
  - HOLD entered from IDLE keeps y=0 and valid=0.
- HOLD to SCAN: resumes with the retained idx and cnt, with no reload from sel or dwell.
- SCAN to DECODE: the next edge shows 1<<sel; the scan position is discarded.
- A dwell change during SCAN takes effect only at the next reload.
- Invariants:
  - valid=1 implies y==(1<<idx) and y is exactly one-hot.
  - valid=0 implies y==0.
  - wrap only asserts while in SCAN, coincident with the first cycle of idx=0.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> y=0, idx=0, valid=0, wrap=0 immediately, without waiting for an edge.
- Decode sweep, N=2: en=1, mode=0, sel=0,1,2,3 on successive edges -> y=0001,0010,0100,1000 one cycle after each sel, valid=1. Then drop en -> y=0000, valid=0 on the next edge.
- Scan, N=2: dwell=2, sel=1, mode=1 from IDLE -> y=0010 for 3 cycles, then 0100 x3, 1000 x3, 0001 x3 (wrap=1 only on the first 0001 cycle), then 0010 again.
- Hold/resume: in the scan above, switch to mode=2 on the 2nd cycle of 0100 for 5 cycles -> y stays 0100. Return to mode=1 -> 0100 for exactly 2 more cycles, then 1000.
- Mode switch and reserved mode: mid-scan switch to mode=0 with sel=3 -> y=1000 on the next edge. Apply mode=3 -> behaves identically to HOLD. Change dwell mid-position -> the new dwell applies only from the next reload.
- Parametrised instance, N=3, dwell=0, sel=6, mode=1 -> y steps 01000000, 10000000, 00000001 (wrap=1), 00000010 ... one step per cycle. wrap pulses every 8 cycles; idx tracks y throughout.
